// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file.
//   state_e    : init-sweep / run state encoding
//   RF_DATA_W  : default register width
//   RF_ADDR_W  : default address width
//   in_range() : true when an address selects an implemented register
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Access bus of the register file: two read ports, one write port, and the
// ready flag.
//   master : pipeline side, drives enables/addresses/write data
//   slave  : register file side, returns registered read data and ready
interface regfile_2r1w_if #(
  parameter int DATA_W = regfile_pkg::RF_DATA_W,
  parameter int ADDR_W = regfile_pkg::RF_ADDR_W
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              ready;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  data_a, data_b, ready
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output data_a, data_b, ready
  );
endinterface

// File: rtl/regfile_init_seq.sv
// INIT/RUN sequencer: after reset it sweeps every register address once so
// the top level can load the init value, then parks in RUN.
//   clock, reset_n : clock and synchronous active-low reset
//   init_we        : sweep write strobe (high for the whole INIT state)
//   init_addr      : register being initialised this cycle
//   ready          : sweep finished, user accesses allowed
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last = (32'(cnt_q) == 32'(DEPTH - 1));

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we = 1'b1;
        if (last) state_d = RUN;
        else      cnt_d   = cnt_q + 1'b1;
      end
      RUN: ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign init_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with hardware init sweep,
// optional write-to-read bypass and optional hardwired zero register.
//   clock, reset_n : clock and synchronous active-low reset
//   bus (slave)    : rd_en/rd_addr_a/rd_addr_b, wr_en/wr_addr/wr_data in;
//                    data_a/data_b (1-cycle registered read data), ready out
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int              DATA_W   = RF_DATA_W,
  parameter int              ADDR_W   = RF_ADDR_W,
  parameter int              DEPTH    = 32,
  parameter int              ZERO_REG = 1,
  parameter int              BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  regfile_2r1w_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              ready;

  regfile_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clock     (clock),
    .reset_n   (reset_n),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A user write takes effect only in RUN, to an implemented, writable entry.
  logic user_we;
  assign user_we = ready && bus.wr_en && in_range(32'(bus.wr_addr), 32'(DEPTH))
                   && !is_zero(bus.wr_addr);

  // Write mux: the sweep owns the array during INIT, the user port in RUN.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = reset_n && (init_we || user_we);
    mem_waddr = init_we ? init_addr : bus.wr_addr;
    mem_wdata = init_we ? INIT_VAL  : bus.wr_data;
  end

  // NOTE: the storage array has no reset; clearing it is the job of the init
  // sweep, which keeps the array mappable to plain RAM/flop arrays.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Zero/out-of-range reads win over the bypass, so r0 stays 0 even when a
  // same-cycle write to r0 is presented.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (!in_range(32'(a), 32'(DEPTH)) || is_zero(a)) return '0;
    if ((BYPASS != 0) && we && (waddr == a))         return wdata;
    return stored;
  endfunction

  logic [DATA_W-1:0] rd_val_a, rd_val_b;

  always_comb begin
    rd_val_a = read_port(bus.rd_addr_a, mem[bus.rd_addr_a], user_we, bus.wr_addr, bus.wr_data);
    rd_val_b = read_port(bus.rd_addr_b, mem[bus.rd_addr_b], user_we, bus.wr_addr, bus.wr_data);
  end

  logic [DATA_W-1:0] data_a_q, data_b_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else if (ready && bus.rd_en) begin
      data_a_q <= rd_val_a;
      data_b_q <= rd_val_b;
    end
  end

  assign bus.data_a = data_a_q;
  assign bus.data_b = data_b_q;
  assign bus.ready  = ready;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w. Two instances share one stimulus stream:
//   dut1 : defaults (ZERO_REG=1, BYPASS=1, INIT_VAL=0)
//   dut0 : ZERO_REG=0, BYPASS=0, INIT_VAL=IV0
module tb_regfile_2r1w;

  localparam logic [31:0] IV0 = 32'h0000_5A5A;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd_en;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  assign bus1.rd_en     = rd_en;
  assign bus1.rd_addr_a = rd_addr_a;
  assign bus1.rd_addr_b = rd_addr_b;
  assign bus1.wr_en     = wr_en;
  assign bus1.wr_addr   = wr_addr;
  assign bus1.wr_data   = wr_data;
  assign bus0.rd_en     = rd_en;
  assign bus0.rd_addr_a = rd_addr_a;
  assign bus0.rd_addr_b = rd_addr_b;
  assign bus0.wr_en     = wr_en;
  assign bus0.wr_addr   = wr_addr;
  assign bus0.wr_data   = wr_data;

  regfile_2r1w #(.DEPTH(32)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  regfile_2r1w #(.DEPTH(32), .ZERO_REG(0), .BYPASS(0), .INIT_VAL(IV0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_en = 1'b1; rd_addr_a = a; rd_addr_b = b; wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; rd_en = 1'b0;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0;

    // Reset for two cycles.
    tick(); tick();
    check("rst_ready1", {31'b0, bus1.ready}, 32'd0);
    check("rst_ready0", {31'b0, bus0.ready}, 32'd0);
    check("rst_a1", bus1.data_a, 32'd0);
    check("rst_b1", bus1.data_b, 32'd0);
    check("rst_a0", bus0.data_a, 32'd0);

    // Sweep: ready stays low for 31 edges, rises on the 32nd.
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("sweep_ready", {31'b0, bus1.ready}, (i == 31) ? 32'd1 : 32'd0);
    end
    check("sweep_ready0", {31'b0, bus0.ready}, 32'd1);

    // Every register holds the init value.
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check("init_a1", bus1.data_a, 32'd0);
      check("init_b1", bus1.data_b, 32'd0);
      check("init_a0", bus0.data_a, IV0);
      check("init_b0", bus0.data_b, IV0);
    end

    // Plain write then read, with r0 on port B.
    wr(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd0);
    check("r5_a1", bus1.data_a, 32'hDEAD_BEEF);
    check("r0_b1", bus1.data_b, 32'd0);
    check("r5_a0", bus0.data_a, 32'hDEAD_BEEF);
    check("r0_b0", bus0.data_b, IV0);

    // Same-cycle write and dual read of r7.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
    rd_en = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("byp_a1", bus1.data_a, 32'h0000_1234);
    check("byp_b1", bus1.data_b, 32'h0000_1234);
    check("nobyp_a0", bus0.data_a, IV0);
    check("nobyp_b0", bus0.data_b, IV0);
    rd(5'd7, 5'd7);
    check("r7_a1", bus1.data_a, 32'h0000_1234);
    check("r7_b0", bus0.data_b, 32'h0000_1234);

    // Writes to r0.
    wr(5'd0, 32'hFFFF_FFFF);
    rd(5'd0, 5'd0);
    check("zero_a1", bus1.data_a, 32'd0);
    check("zero_b1", bus1.data_b, 32'd0);
    check("nozero_a0", bus0.data_a, 32'hFFFF_FFFF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1111;
    rd_en = 1'b1; rd_addr_a = 5'd0; rd_addr_b = 5'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("zero_byp_a1", bus1.data_a, 32'd0);
    check("zero_byp_b1", bus1.data_b, 32'hDEAD_BEEF);
    check("zero_old_a0", bus0.data_a, 32'hFFFF_FFFF);

    // Hold with rd_en low while r5 is rewritten.
    rd(5'd5, 5'd7);
    check("hold_pre_a1", bus1.data_a, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      wr(5'd5, 32'hCAFE_0005 + 32'(i));
      check("hold_a1", bus1.data_a, 32'hDEAD_BEEF);
      check("hold_b1", bus1.data_b, 32'h0000_1234);
      check("hold_a0", bus0.data_a, 32'hDEAD_BEEF);
    end
    rd(5'd5, 5'd5);
    check("hold_new_a1", bus1.data_a, 32'hCAFE_0007);
    check("hold_new_b0", bus0.data_b, 32'hCAFE_0007);

    // Reset mid-RUN; enables held high through the new sweep must be ignored.
    wr(5'd3, 32'h0000_00A5);
    rd(5'd3, 5'd3);
    check("r3_a1", bus1.data_a, 32'h0000_00A5);
    reset_n = 1'b0;
    rd_en = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0BAD;
    tick();
    check("mid_rst_a1", bus1.data_a, 32'd0);
    check("mid_rst_b1", bus1.data_b, 32'd0);
    check("mid_rst_ready1", {31'b0, bus1.ready}, 32'd0);
    check("mid_rst_a0", bus0.data_a, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("resweep_ready", {31'b0, bus1.ready}, (i == 31) ? 32'd1 : 32'd0);
    end
    check("resweep_a1", bus1.data_a, 32'd0);
    check("resweep_a0", bus0.data_a, 32'd0);
    rd_en = 1'b0; wr_en = 1'b0;
    rd(5'd3, 5'd7);
    check("r3_init_a1", bus1.data_a, 32'd0);
    check("r7_init_b1", bus1.data_b, 32'd0);
    check("r3_init_a0", bus0.data_a, IV0);
    check("r7_init_b0", bus0.data_b, IV0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
